// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demultiplexer: one hold register plus a per-channel
// pending mask. It supports unicast and broadcast delivery and flags out-of-range selects.
module stream_demux_1ton #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    err_sel
);

  localparam logic [SEL_W:0] N_OUT_W = (SEL_W + 1)'(N_OUT);

  logic [N_OUT-1:0]  pend_q, pend_d;
  logic [N_OUT-1:0]  sel_onehot;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              err_q, err_d;
  logic              drain;
  logic              accept;
  logic              sel_legal;

  // Ready depends only on the mask and the consumers, never on in_valid.
  assign drain     = ((pend_q & ~out_ready) == '0);
  assign in_ready  = (pend_q == '0) | drain;
  assign accept    = in_valid & in_ready;
  assign sel_legal = ({1'b0, in_sel} < N_OUT_W);

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_chan
      assign sel_onehot[gi] = (in_sel == SEL_W'(gi));
      assign out_data[gi*DATA_W +: DATA_W] = hold_q;
    end
  endgenerate

  assign out_valid = pend_q;
  assign err_sel   = err_q;

  // A new word replaces the mask outright; old bits completing this cycle are
  // already covered by drain, so nothing is delivered twice.
  always_comb begin
    pend_d = pend_q & ~out_ready;
    hold_d = hold_q;
    err_d  = 1'b0;
    if (accept) begin
      hold_d = in_data;
      if (in_bcast) begin
        pend_d = '1;
      end else if (sel_legal) begin
        pend_d = sel_onehot;
      end else begin
        pend_d = '0;
        err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      hold_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      hold_q <= hold_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Bench for stream_demux_1ton: directed tests on a 6-channel instance and a
// random-traffic run on a 2-channel 32-bit instance, both checked by per-channel scoreboards.
module tb_stream_demux_1ton;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: DATA_W=8, N_OUT=6, SEL_W=3 (selects 6 and 7 are illegal)
  logic        rst_a_n;
  logic        a_in_valid, a_in_ready, a_in_bcast, a_err;
  logic [7:0]  a_in_data;
  logic [2:0]  a_in_sel;
  logic [5:0]  a_out_valid, a_out_ready;
  logic [47:0] a_out_data;

  // Instance B: DATA_W=32, N_OUT=2, SEL_W=1
  logic        rst_b_n;
  logic        b_in_valid, b_in_ready, b_in_bcast, b_err;
  logic [31:0] b_in_data;
  logic [0:0]  b_in_sel;
  logic [1:0]  b_out_valid, b_out_ready;
  logic [63:0] b_out_data;
  bit          b_done = 1'b0;

  stream_demux_1ton #(.DATA_W(8), .N_OUT(6), .SEL_W(3)) dut_a (
    .clk(clk), .rst_n(rst_a_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_sel(a_in_sel), .in_bcast(a_in_bcast),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .err_sel(a_err)
  );

  stream_demux_1ton #(.DATA_W(32), .N_OUT(2), .SEL_W(1)) dut_b (
    .clk(clk), .rst_n(rst_b_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sel(b_in_sel), .in_bcast(b_in_bcast),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .err_sel(b_err)
  );

  // Scoreboards: expected words per channel, filled by the drivers.
  logic [7:0]  qa[6][$];
  logic [31:0] qb[2][$];
  logic [7:0]  a_exp;
  logic [31:0] b_exp;
  int a_err_seen = 0;
  int a_err_exp  = 0;
  int b_err_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void a_push(input logic [7:0] d, input int sel, input bit bc);
    $display("A accept data=0x%02h sel=%0d bcast=%0d", d, sel, bc);
    if (bc) begin
      for (int j = 0; j < 6; j++) qa[j].push_back(d);
    end else if (sel < 6) begin
      qa[sel].push_back(d);
    end else begin
      a_err_exp++;
    end
  endfunction

  // Monitor A: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_a_n) begin
      for (int i = 0; i < 6; i++) begin
        if (a_out_valid[i] && a_out_ready[i]) begin
          if (qa[i].size() == 0) begin
            check("a_spurious_valid", 64'(a_out_valid[i]), 64'd0);
          end else begin
            a_exp = qa[i].pop_front();
            $display("A deliver ch%0d data=0x%02h", i, a_out_data[i*8 +: 8]);
            check("a_out_data", 64'(a_out_data[i*8 +: 8]), 64'(a_exp));
          end
        end
      end
      if (a_err) a_err_seen++;
    end
  end

  always @(negedge clk) begin
    if (rst_b_n) begin
      for (int i = 0; i < 2; i++) begin
        if (b_out_valid[i] && b_out_ready[i]) begin
          if (qb[i].size() == 0) begin
            check("b_spurious_valid", 64'(b_out_valid[i]), 64'd0);
          end else begin
            b_exp = qb[i].pop_front();
            $display("B deliver ch%0d data=0x%08h", i, b_out_data[i*32 +: 32]);
            check("b_out_data", 64'(b_out_data[i*32 +: 32]), 64'(b_exp));
          end
        end
      end
      if (b_err) b_err_seen++;
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic a_send(input logic [7:0] d, input int sel, input bit bc);
    bit done = 1'b0;
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_sel   = 3'(sel);
    a_in_bcast = bc;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (a_in_ready) begin
        done = 1'b1;
        a_push(d, sel, bc);
      end
      @(posedge clk); #1;
    end
    if (!done) check("a_accept_timeout", 64'(a_in_ready), 64'd1);
    a_in_valid = 1'b0;
    a_in_data  = 8'hC3;
    a_in_sel   = 3'd6;
  endtask

  task automatic b_send(input logic [31:0] d, input int sel, input bit bc);
    bit done = 1'b0;
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_sel   = 1'(sel);
    b_in_bcast = bc;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (b_in_ready) begin
        done = 1'b1;
        $display("B accept data=0x%08h sel=%0d bcast=%0d", d, sel, bc);
        if (bc) begin
          qb[0].push_back(d);
          qb[1].push_back(d);
        end else begin
          qb[sel].push_back(d);
        end
      end
      @(posedge clk); #1;
    end
    if (!done) check("b_accept_timeout", 64'(b_in_ready), 64'd1);
    b_in_valid = 1'b0;
    b_in_data  = $urandom;
  endtask

  // Random consumer readiness for instance B; all-ready once traffic stops.
  initial begin
    b_out_ready = 2'b00;
    forever begin
      @(posedge clk); #1;
      b_out_ready = b_done ? 2'b11 : 2'($urandom_range(0, 3));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a_n = 1'b0;  rst_b_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = 8'h00; a_in_sel = 3'd0; a_in_bcast = 1'b0;
    a_out_ready = 6'h3F;
    b_in_valid = 1'b0; b_in_data = 32'h0; b_in_sel = 1'b0; b_in_bcast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_a_n = 1'b1;  rst_b_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(a_out_valid), 64'h0);
    check("rst_in_ready", 64'(a_in_ready), 64'h1);
    check("rst_err_sel", 64'(a_err), 64'h0);
    @(posedge clk); #1;

    // Unicast sweep, back to back: one word per cycle
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'hA0 + i);
      a_in_sel   = 3'(i);
      a_in_bcast = 1'b0;
      @(negedge clk);
      check("sweep_in_ready", 64'(a_in_ready), 64'h1);
      if (i > 0) check("sweep_out_valid", 64'(a_out_valid), 64'(1 << (i - 1)));
      if (a_in_ready) a_push(8'(8'hA0 + i), i, 1'b0);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    check("sweep_last_valid", 64'(a_out_valid), 64'h20);
    @(posedge clk); #1;

    // Backpressure on channel 3
    a_out_ready = 6'h37;
    a_send(8'h5C, 3, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(a_out_valid), 64'h08);
      check("bp_out_data", 64'(a_out_data[31:24]), 64'h5C);
      check("bp_in_ready", 64'(a_in_ready), 64'h0);
      @(posedge clk); #1;
    end
    a_out_ready = 6'h3F;
    @(negedge clk);
    check("bp_release_valid", 64'(a_out_valid), 64'h08);
    check("bp_release_ready", 64'(a_in_ready), 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_after_valid", 64'(a_out_valid), 64'h00);
    @(posedge clk); #1;

    // Broadcast with partial drain, next word accepted on the final drain edge
    a_out_ready = 6'h00;
    a_send(8'h3E, 0, 1'b1);
    a_out_ready = 6'h07;
    @(negedge clk);
    check("bc_all_valid", 64'(a_out_valid), 64'h3F);
    check("bc_in_ready_busy", 64'(a_in_ready), 64'h0);
    @(posedge clk); #1;
    a_out_ready = 6'h38;
    a_in_valid = 1'b1; a_in_data = 8'h77; a_in_sel = 3'd1; a_in_bcast = 1'b0;
    @(negedge clk);
    check("bc_rest_valid", 64'(a_out_valid), 64'h38);
    check("bc_drain_ready", 64'(a_in_ready), 64'h1);
    if (a_in_ready) a_push(8'h77, 1, 1'b0);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_out_ready = 6'h00;
    @(negedge clk);
    check("bc_next_valid", 64'(a_out_valid), 64'h02);
    check("bc_next_data", 64'(a_out_data), {6{8'h77}});
    @(posedge clk); #1;
    a_out_ready = 6'h3F;
    @(posedge clk); #1;
    @(negedge clk);
    check("bc_empty", 64'(a_out_valid), 64'h00);
    @(posedge clk); #1;

    // Illegal select: dropped, one-cycle error pulse, next word normal
    a_send(8'h11, 7, 1'b0);
    @(negedge clk);
    check("ill_err_pulse", 64'(a_err), 64'h1);
    check("ill_out_valid", 64'(a_out_valid), 64'h00);
    check("ill_in_ready", 64'(a_in_ready), 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("ill_err_clear", 64'(a_err), 64'h0);
    @(posedge clk); #1;
    a_send(8'h55, 5, 1'b0);
    @(negedge clk);
    check("ill_next_valid", 64'(a_out_valid), 64'h20);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a broadcast
    a_out_ready = 6'h00;
    a_send(8'h99, 0, 1'b1);
    @(negedge clk);
    check("rstm_pending", 64'(a_out_valid), 64'h3F);
    #2 rst_a_n = 1'b0;
    #1;
    check("rstm_out_valid", 64'(a_out_valid), 64'h00);
    check("rstm_in_ready", 64'(a_in_ready), 64'h1);
    check("rstm_out_data", 64'(a_out_data), 64'h0);
    for (int j = 0; j < 6; j++) qa[j].delete();
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    a_out_ready = 6'h3F;
    @(negedge clk);
    check("rstm_after_valid", 64'(a_out_valid), 64'h00);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstm_no_stale", 64'(a_out_valid), 64'h00);

    for (int j = 0; j < 6; j++) check("a_queue_empty", 64'(qa[j].size()), 64'd0);
    check("a_err_pulses", 64'(a_err_seen), 64'(a_err_exp));

    // Corner instance: random traffic, 1000 words
    @(posedge clk); #1;
    for (int w = 0; w < 1000; w++) begin
      if ($urandom_range(0, 3) == 0) begin
        b_in_data = $urandom;
        @(posedge clk); #1;
      end
      b_send($urandom, int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    b_done = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 2; j++) check("b_queue_empty", 64'(qb[j].size()), 64'd0);
    check("b_out_valid_idle", 64'(b_out_valid), 64'h0);
    check("b_err_pulses", 64'(b_err_seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1toN

Overview:
- Registered 1-to-N stream demultiplexer with a valid/ready handshake. It is the parametrised successor of the team's fixed 1-to-8 combinational demux.
- Routes each input word to the output channel chosen by in_sel, or to all channels in broadcast mode.
- Sits between a single producer and N independent consumers. Each consumer may apply backpressure independently.

Parameters:
- DATA_W, 8, width of the data word.
- N_OUT, 8, number of output channels; legal range 2..64.
- SEL_W, 3, width of in_sel; must satisfy 2**SEL_W >= N_OUT.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer word valid.
- in_ready  output  1  demux can accept the word this cycle.
- in_data  input  DATA_W  input word.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  1 = deliver the word to every channel; in_sel is ignored.
- out_valid  output  N_OUT  per-channel valid.
- out_ready  input  N_OUT  per-channel ready.
- out_data  output  N_OUT*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]; all channels carry the same hold-register word.
- err_sel  output  1  one-cycle pulse: a word with in_sel >= N_OUT was dropped.

Behaviour:
- State: one hold register (hold_data, DATA_W) plus a pending mask (pend, N_OUT bits). The mask is the only state machine. "Empty" means pend == 0; "busy" means pend != 0.
- out_valid = pend, out_data = hold_data replicated to every channel, directly from flops with no combinational path from inputs.
- Per-channel handshake: channel i completes when out_valid[i] & out_ready[i]. Its pend bit clears on that clock edge.
- drain = (pend & ~out_ready) == 0, meaning every pending channel completes this cycle.
- in_ready = (pend == 0) | drain. This is combinational from pend and out_ready only, never from in_valid.
- Accept when in_valid & in_ready. On the accepting edge:
  - hold_data <= in_data.
  - If in_bcast: pend <= all ones.
  - Otherwise, if in_sel < N_OUT: pend <= one-hot(in_sel).
  - Otherwise the word is dropped: pend <= 0, err_sel pulses 1 on the next cycle, and the word is consumed (in_ready was 1).
- Latency: a word accepted at edge k is visible on out_valid at edge k. Output is available in the cycle after acceptance.
- Throughput: one word per cycle when the destination is ready every cycle, including back-to-back accepts with drain true.
- Broadcast: each channel drains independently. A new word is accepted only once the last pending bit clears, or clears in the same cycle. Channels that already took the word see no valid until the next word.
- Simultaneous accept and drain: the new pend replaces the old one. Bits of the old word clear as they complete, with no double delivery.
- Not accepted and not drained: hold_data and pend are held stable. out_valid stays asserted until the handshake completes, and out_data does not change while any out_valid bit is high.
- in_valid = 0: no state change beyond per-channel clears.
- X or changing in_data/in_sel while in_valid = 0 has no effect.
- Reset (async assert, any cycle including mid-broadcast):
  - pend = 0, hold_data = 0, err_sel = 0, so out_valid = 0 and in_ready = 1.
  - A pending word is discarded.
  - Deassertion is synchronised externally; the first accept is possible on the first edge after release.
- When N_OUT is a power of two with 2**SEL_W == N_OUT, err_sel is constant 0.

Test Plan:
- Unicast sweep: N_OUT=8, all out_ready=1; send data 0xA0+i with sel=i for i=0..7 back to back → out_valid = 1<<i one cycle after each accept, matching data, in_ready held 1, 8 words in 8 cycles.
- Backpressure: sel=3, data 0x5C, out_ready[3]=0 for 4 cycles → out_valid=0x08 and data 0x5C stable for 4 cycles, in_ready=0. Release ready → single transfer, then in_ready=1.
- Broadcast partial drain: bcast data 0x3E; out_ready alternates 0x0F then 0xF0 → pend goes 0xFF→0xF0→0x00. A second word offered during the 0xF0 cycle is accepted on that edge (drain true) and appears next cycle.
- Illegal select: N_OUT=6, SEL_W=3, sel=7, data 0x11 → accepted, out_valid stays 0, err_sel=1 for exactly one cycle. A following sel=5 word is delivered normally.
- Reset mid-operation: bcast pending with out_ready=0, assert rst_n low asynchronously mid-cycle → out_valid=0 and in_ready=1 immediately. After release, no stale word appears.
- Parameter corner: DATA_W=32, N_OUT=2, SEL_W=1, random valid/ready for 1000 words → scoreboard: every word delivered once per target channel, in order, none lost or duplicated.
